// File: rtl/cam_pkg.sv
// cam_pkg: shared defaults, command opcodes and controller states for the CAM command controller
package cam_pkg;
  localparam int WIDTH_DEF      = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SEARCH, OP_INSERT} cmd_op_e;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_INSERT_WR, S_RESP} state_e;
endpackage

// File: rtl/cam_free_finder.sv
// cam_free_finder: lowest clear entry of the valid bitmap plus an all-full flag
//   bitmap_i   : one valid bit per CAM entry
//   free_idx_o : lowest index whose bit is clear (0 when full)
//   full_o     : every entry valid
module cam_free_finder #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [2**ADDR_WIDTH-1:0] bitmap_i,
  output logic [ADDR_WIDTH-1:0]    free_idx_o,
  output logic                     full_o
);
  always_comb begin
    free_idx_o = '0;
    for (int i = 2**ADDR_WIDTH-1; i >= 0; i--)
      if (!bitmap_i[i]) free_idx_o = ADDR_WIDTH'(i);
  end
  assign full_o = &bitmap_i;
endmodule

// File: rtl/cam_cmd_ctrl.sv
// cam_cmd_ctrl: sequences READ/WRITE/SEARCH/INSERT commands onto a CAM and returns one response each
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   cmd_*                        : command handshake (accepted only in IDLE)
//   read/write/search_*_o        : single-cycle CAM strobes with index/data
//   read_*_i, search_*_i         : CAM results, sampled CAM_LATENCY cycles after the strobe
//   rsp_*                        : response, held until rsp_ready_i
module cam_cmd_ctrl
  import cam_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int CAM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_index_i,
  input  logic [WIDTH-1:0]      cmd_data_i,
  output logic                  read_enable_o,
  output logic                  write_enable_o,
  output logic                  search_enable_o,
  output logic [ADDR_WIDTH-1:0] read_index_o,
  output logic [ADDR_WIDTH-1:0] write_index_o,
  output logic [WIDTH-1:0]      write_data_o,
  output logic [WIDTH-1:0]      search_data_o,
  input  logic                  read_valid_i,
  input  logic                  search_valid_i,
  input  logic [WIDTH-1:0]      read_value_i,
  input  logic [ADDR_WIDTH-1:0] search_index_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_hit_o,
  output logic                  rsp_full_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o,
  output logic [WIDTH-1:0]      rsp_data_o
);
  localparam int N  = 2**ADDR_WIDTH;
  localparam int CW = $clog2(CAM_LATENCY + 1);
  state_e                state_q, state_d;
  cmd_op_e               op_q, op_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d, rsp_index_q, rsp_index_d, free_idx;
  logic [WIDTH-1:0]      data_q, data_d, rsp_data_q, rsp_data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [N-1:0]          bitmap_q, bitmap_d;
  logic                  rsp_hit_q, rsp_hit_d, rsp_full_q, rsp_full_d, full;
  cam_free_finder #(.ADDR_WIDTH(ADDR_WIDTH)) u_free (
    .bitmap_i   (bitmap_q),
    .free_idx_o (free_idx),
    .full_o     (full)
  );
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    index_d     = index_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    bitmap_d    = bitmap_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_full_d  = rsp_full_q;
    rsp_index_d = rsp_index_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        state_d = S_ISSUE;
        op_d    = cmd_op_e'(cmd_op_i);
        index_d = cmd_index_i;
        data_d  = cmd_data_i;
      end
      S_ISSUE: begin
        // the strobe cycle counts as the first latency cycle
        cnt_d       = CW'(1);
        rsp_hit_d   = op_q == OP_WRITE;
        rsp_full_d  = 1'b0;
        rsp_index_d = op_q == OP_WRITE ? index_q : '0;
        rsp_data_d  = '0;
        state_d     = op_q == OP_WRITE ? S_RESP : S_WAIT;
        if (op_q == OP_WRITE) bitmap_d[index_q] = 1'b1;
      end
      S_WAIT: if (cnt_q != CW'(CAM_LATENCY)) cnt_d = cnt_q + CW'(1);
      else begin
        state_d = S_RESP;
        case (op_q)
          OP_READ: begin
            rsp_hit_d   = read_valid_i;
            rsp_data_d  = read_value_i;
            rsp_index_d = index_q;
          end
          OP_SEARCH: begin
            rsp_hit_d   = search_valid_i;
            rsp_index_d = search_valid_i ? search_index_i : '0;
          end
          default: begin
            rsp_hit_d   = search_valid_i;
            rsp_full_d  = !search_valid_i && full;
            rsp_index_d = search_valid_i ? search_index_i : full ? '0 : free_idx;
            state_d     = !search_valid_i && !full ? S_INSERT_WR : S_RESP;
          end
        endcase
      end
      S_INSERT_WR: begin
        bitmap_d[rsp_index_q] = 1'b1;
        state_d               = S_RESP;
      end
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      index_q     <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      bitmap_q    <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_full_q  <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      index_q     <= index_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      bitmap_q    <= bitmap_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_full_q  <= rsp_full_d;
      rsp_index_q <= rsp_index_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
  assign cmd_ready_o     = state_q == S_IDLE;
  assign read_enable_o   = state_q == S_ISSUE && op_q == OP_READ;
  assign write_enable_o  = (state_q == S_ISSUE && op_q == OP_WRITE) || state_q == S_INSERT_WR;
  assign search_enable_o = state_q == S_ISSUE && (op_q == OP_SEARCH || op_q == OP_INSERT);
  assign read_index_o    = read_enable_o ? index_q : '0;
  // an allocating write targets the index already latched for the response
  assign write_index_o   = state_q == S_INSERT_WR ? rsp_index_q : write_enable_o ? index_q : '0;
  assign write_data_o    = write_enable_o ? data_q : '0;
  assign search_data_o   = search_enable_o ? data_q : '0;
  assign rsp_valid_o     = state_q == S_RESP;
  assign rsp_hit_o       = rsp_hit_q;
  assign rsp_full_o      = rsp_full_q;
  assign rsp_index_o     = rsp_index_q;
  assign rsp_data_o      = rsp_data_q;
endmodule

// File: tb/tb_cam_cmd_ctrl.sv
// tb_cam_cmd_ctrl: table-driven and scoreboard check of cam_cmd_ctrl against a behavioural CAM
module tb_cam_cmd_ctrl;
  import cam_pkg::*;
  typedef struct {
    logic        hit;
    logic        full;
    logic [4:0]  idx;
    logic [31:0] data;
    int          lat;
    int          stb;
    int          wr;
  } exp_t;
  typedef struct {
    cmd_op_e     op;
    logic [4:0]  idx;
    logic [31:0] data;
    exp_t        e;
  } vec_t;
  logic clk = 1'b0, rst_i = 1'b1;
  logic cmd_valid_i = 1'b0, cmd_ready_o, rsp_ready_i = 1'b1;
  logic [1:0] cmd_op_i = '0;
  logic [4:0] cmd_index_i = '0, read_index_o, write_index_o, search_index_i, rsp_index_o;
  logic [31:0] cmd_data_i = '0, write_data_o, search_data_o, read_value_i, rsp_data_o;
  logic read_enable_o, write_enable_o, search_enable_o, read_valid_i, search_valid_i;
  logic rsp_valid_o, rsp_hit_o, rsp_full_o;
  logic [31:0] cam_mem [32];
  logic [31:0] cam_vld;
  exp_t sb[$];
  vec_t tbl[13];
  int tests = 0, fails = 0;
  int cyc = 0, acc = 0, lat = 0, nstb = 0, nwr = 0;
  bit seen = 0;
  always #5 clk = ~clk;
  cam_cmd_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_index_i(cmd_index_i), .cmd_data_i(cmd_data_i),
    .read_enable_o(read_enable_o), .write_enable_o(write_enable_o), .search_enable_o(search_enable_o),
    .read_index_o(read_index_o), .write_index_o(write_index_o), .write_data_o(write_data_o),
    .search_data_o(search_data_o), .read_valid_i(read_valid_i), .search_valid_i(search_valid_i),
    .read_value_i(read_value_i), .search_index_i(search_index_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o), .rsp_full_o(rsp_full_o),
    .rsp_index_o(rsp_index_o), .rsp_data_o(rsp_data_o)
  );
  // behavioural CAM with one cycle of latency; result buses carry noise outside result cycles
  always @(posedge clk) begin
    logic       hit;
    logic [4:0] hi;
    hit = 1'b0;
    hi  = '0;
    for (int i = 31; i >= 0; i--)
      if (cam_vld[i] && cam_mem[i] == search_data_o) begin
        hit = 1'b1;
        hi  = 5'(i);
      end
    if (rst_i) cam_vld <= '0;
    else if (write_enable_o) begin
      cam_mem[write_index_o] <= write_data_o;
      cam_vld[write_index_o] <= 1'b1;
    end
    read_valid_i   <= read_enable_o && cam_vld[read_index_o];
    read_value_i   <= read_enable_o ? (cam_vld[read_index_o] ? cam_mem[read_index_o] : 32'h0) : $urandom();
    search_valid_i <= search_enable_o && hit;
    search_index_i <= search_enable_o ? hi : 5'($urandom_range(31, 0));
  end
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // response monitor: latency, strobe counts and scoreboard compare
  always @(negedge clk) begin
    cyc++;
    if (rst_i) seen = 0;
    else begin
      if (cmd_valid_i && cmd_ready_o) begin
        acc  = cyc;
        nstb = 0;
        nwr  = 0;
        seen = 0;
      end
      nstb += int'(read_enable_o) + int'(write_enable_o) + int'(search_enable_o);
      if (write_enable_o) nwr++;
      if (rsp_valid_o && !seen) begin
        seen = 1;
        lat  = cyc - acc;
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got response index %0h, expected none", rsp_index_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_hit", rsp_hit_o, e.hit);
          chk("rsp_full", rsp_full_o, e.full);
          chk("rsp_index", rsp_index_o, e.idx);
          chk("rsp_data", rsp_data_o, e.data);
          chk("latency", lat, e.lat);
          chk("strobes", nstb, e.stb);
          chk("writes", nwr, e.wr);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask
  task automatic send(cmd_op_e op, logic [4:0] idx, logic [31:0] data);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_index_i = idx;
    cmd_data_i  = data;
    while (!cmd_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready_o) begin
      tests++;
      fails++;
      $display("FAIL cmd_timeout: cmd_ready_o %0b expected 1", cmd_ready_o);
    end
    tick();
    cmd_valid_i = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: %0d responses pending, expected 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic run(vec_t v);
    sb.push_back(v.e);
    send(v.op, v.idx, v.data);
    drain();
  endtask
  initial begin
    vec_t v;
    int n;
    tbl[0]  = '{OP_WRITE,  5'd3, 32'hDEADBEEF, '{1'b1, 1'b0, 5'd3, 32'h0,        2, 1, 1}};
    tbl[1]  = '{OP_READ,   5'd3, 32'h0,        '{1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 3, 1, 0}};
    tbl[2]  = '{OP_INSERT, 5'd9, 32'h12345678, '{1'b0, 1'b0, 5'd0, 32'h0,        4, 2, 1}};
    tbl[3]  = '{OP_SEARCH, 5'd0, 32'h12345678, '{1'b1, 1'b0, 5'd0, 32'h0,        3, 1, 0}};
    tbl[4]  = '{OP_SEARCH, 5'd0, 32'hDEADBEEF, '{1'b1, 1'b0, 5'd3, 32'h0,        3, 1, 0}};
    tbl[5]  = '{OP_SEARCH, 5'd6, 32'h0BADF00D, '{1'b0, 1'b0, 5'd0, 32'h0,        3, 1, 0}};
    tbl[6]  = '{OP_INSERT, 5'd0, 32'h12345678, '{1'b1, 1'b0, 5'd0, 32'h0,        3, 1, 0}};
    tbl[7]  = '{OP_INSERT, 5'd0, 32'hCAFEF00D, '{1'b0, 1'b0, 5'd1, 32'h0,        4, 2, 1}};
    tbl[8]  = '{OP_READ,   5'd7, 32'h0,        '{1'b0, 1'b0, 5'd7, 32'h0,        3, 1, 0}};
    tbl[9]  = '{OP_WRITE,  5'd2, 32'h55AA55AA, '{1'b1, 1'b0, 5'd2, 32'h0,        2, 1, 1}};
    tbl[10] = '{OP_INSERT, 5'd0, 32'h77777777, '{1'b0, 1'b0, 5'd4, 32'h0,        4, 2, 1}};
    tbl[11] = '{OP_READ,   5'd1, 32'h0,        '{1'b1, 1'b0, 5'd1, 32'hCAFEF00D, 3, 1, 0}};
    tbl[12] = '{OP_SEARCH, 5'd0, 32'h55AA55AA, '{1'b1, 1'b0, 5'd2, 32'h0,        3, 1, 0}};
    do_reset();
    chk("reset_outputs", {read_enable_o, write_enable_o, search_enable_o, read_index_o, write_index_o,
        rsp_valid_o, rsp_hit_o, rsp_full_o, rsp_index_o, (write_data_o | search_data_o | rsp_data_o)}, 64'h0);
    chk("reset_cmd_ready", cmd_ready_o, 1'b1);
    for (int i = 0; i < 13; i++) run(tbl[i]);
    rsp_ready_i = 1'b0;
    sb.push_back('{1'b1, 1'b0, 5'd3, 32'h0, 3, 1, 0});
    send(OP_SEARCH, 5'd0, 32'hDEADBEEF);
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_rsp", {rsp_valid_o, rsp_hit_o, rsp_full_o, rsp_index_o, rsp_data_o, cmd_ready_o},
          {1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 1'b0});
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    chk("idle_after_rsp", cmd_ready_o, 1'b1);
    drain();
    send(OP_READ, 5'd3, 32'h0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("reset_mid_wait_idle", cmd_ready_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("reset_drops_rsp", rsp_valid_o, 1'b0);
      tick();
    end
    v = '{OP_INSERT, 5'd0, 32'h31415926, '{1'b0, 1'b0, 5'd0, 32'h0, 4, 2, 1}};
    run(v);
    do_reset();
    for (int i = 0; i < 32; i++) begin
      v = '{OP_INSERT, 5'd0, 32'hA5000000 | 32'(i), '{1'b0, 1'b0, 5'(i), 32'h0, 4, 2, 1}};
      run(v);
    end
    v = '{OP_INSERT, 5'd0, 32'hA5000100, '{1'b0, 1'b1, 5'd0, 32'h0, 3, 1, 0}};
    run(v);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cam_cmd_ctrl.md
CAM_CMD_CTRL -- requirements
Module: cam_cmd_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data word width; ADDR_WIDTH, default 5, entry index width (32 entries); CAM_LATENCY, default 1, cycles from CAM enable to valid CAM result.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; ports SHALL be as follows:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_op_i  in  2  0=READ, 1=WRITE, 2=SEARCH, 3=INSERT
- cmd_index_i  in  ADDR_WIDTH  entry for READ/WRITE
- cmd_data_i  in  WIDTH  data for WRITE/SEARCH/INSERT
- read_enable_o, write_enable_o, search_enable_o  out  1 each  CAM strobes
- read_index_o, write_index_o  out  ADDR_WIDTH  CAM indices
- write_data_o, search_data_o  out  WIDTH  CAM data
- read_valid_i, search_valid_i  in  1 each  CAM result valid
- read_value_i  in  WIDTH  CAM read data
- search_index_i  in  ADDR_WIDTH  CAM match index
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_hit_o  out  1  READ/SEARCH/INSERT hit, WRITE done
- rsp_full_o  out  1  INSERT miss with no free entry
- rsp_index_o  out  ADDR_WIDTH  matched or allocated index
- rsp_data_o  out  WIDTH  READ data, else 0

Function
REQ-003 States SHALL be IDLE, ISSUE, WAIT, INSERT_WR, RESP.
REQ-004 cmd_ready_o SHALL be high only in IDLE; a command is captured on cmd_valid_i & cmd_ready_o, IDLE->ISSUE.
REQ-005 In ISSUE the block SHALL assert exactly one CAM strobe for one cycle (READ->read, WRITE->write, SEARCH/INSERT->search), with index/data from the captured command.
REQ-006 WRITE SHALL set the entry's bit in a WIDTH-independent 2**ADDR_WIDTH valid bitmap and go ISSUE->RESP with rsp_hit_o=1, rsp_index_o=index.
REQ-007 READ/SEARCH/INSERT SHALL go ISSUE->WAIT, count CAM_LATENCY cycles from the strobe, sample CAM results on the final cycle.
REQ-008 READ: rsp_hit_o=read_valid_i, rsp_data_o=read_value_i, rsp_index_o=index. SEARCH: rsp_hit_o=search_valid_i, rsp_index_o=search_index_i on hit, 0 on miss.
REQ-009 INSERT hit SHALL respond hit with search_index_i and perform no write.
REQ-010 INSERT miss with a free entry SHALL go WAIT->INSERT_WR, write cmd data to the lowest-index clear bitmap entry for one cycle, set that bit, respond rsp_hit_o=0, rsp_full_o=0, rsp_index_o=allocated index.
REQ-011 INSERT miss with bitmap all ones SHALL go WAIT->RESP with rsp_full_o=1, rsp_index_o=0, no write.
REQ-012 RESP SHALL hold rsp_valid_o and all rsp_* stable until rsp_ready_i; on rsp_valid_o & rsp_ready_i go to IDLE.
REQ-013 Latency (CAM_LATENCY=1, no backpressure): accept cycle T; strobe T+1; rsp_valid_o T+3 for READ/SEARCH/INSERT hit or full, T+4 for INSERT allocate, T+2 for WRITE.
REQ-014 CAM strobes SHALL be low in every state other than ISSUE and INSERT_WR; CAM result inputs outside the sample cycle SHALL be ignored.

Reset
REQ-015 rst_i SHALL, at any state including mid-operation, force IDLE, clear the valid bitmap, drive all strobes, rsp_valid_o, rsp_hit_o, rsp_full_o low and all index/data outputs to 0; in-flight commands are dropped without response.

Structure
REQ-016 Package cam_pkg SHALL hold WIDTH/ADDR_WIDTH defaults, the cmd_op enum and the state enum.
REQ-017 Sub-module cam_free_finder SHALL compute lowest clear bitmap index plus an all-full flag, combinationally.

Verification
REQ-018 After reset: WRITE idx 3 data 0xDEADBEEF -> write_enable_o pulse, write_index_o=3, response hit=1 index=3 at T+2.
REQ-019 READ idx 3 with CAM returning 0xDEADBEEF -> rsp_hit_o=1, rsp_data_o=0xDEADBEEF at T+3.
REQ-020 INSERT 0x12345678, CAM miss, bitmap {3} -> write to idx 0, response hit=0 full=0 index=0 at T+4.
REQ-021 32 INSERT misses fill table; 33rd INSERT miss -> rsp_full_o=1, no write strobe.
REQ-022 SEARCH response held with rsp_ready_i low 5 cycles -> outputs stable, cmd_ready_o low; ready high -> IDLE next cycle.
REQ-023 rst_i asserted in WAIT -> IDLE next cycle, no rsp_valid_o, following INSERT miss allocates idx 0.
